// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, state encoding and opcode helpers for the ALU and its command driver
package alu_pkg;

  localparam logic [3:0] OP_ADD        = 4'b0000;
  localparam logic [3:0] OP_SUB        = 4'b0001;
  localparam logic [3:0] OP_AND        = 4'b0010;
  localparam logic [3:0] OP_OR         = 4'b0011;
  localparam logic [3:0] OP_XOR        = 4'b0100;
  localparam logic [3:0] OP_SHL        = 4'b0101;
  localparam logic [3:0] OP_SHR        = 4'b0110;
  localparam logic [3:0] OP_LAST_LEGAL = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Single-bit shift opcodes; the driver iterates these for multi-bit shifts.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  // Legal opcodes are the contiguous range starting at ADD.
  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 16-bit ALU (add/sub/logic/single-bit shifts) driven by alu_cmd_driver
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o
);

  // Pure combinational datapath; illegal opcodes yield zero.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SHL:  result_o = a_i << 1;
      OP_SHR:  result_o = a_i >> 1;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - command/response front end for the ALU with iterated multi-bit shifts (option: ALU_CMD_DRIVER_CNT_EN adds done_cnt)
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_CMD_DRIVER_CNT_EN
  output logic             rsp_err,
  output logic [15:0]      done_cnt
`else
  output logic             rsp_err
`endif
);

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] alu_a_q,    alu_a_d;
  logic [WIDTH-1:0] alu_b_q,    alu_b_d;
  logic [3:0]       alu_op_q,   alu_op_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q,  rsp_err_d;

  // Ready only while idle and out of reset; held low during reset.
  assign cmd_ready = rst_n && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= OP_ADD;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state logic: load in IDLE, iterate shifts in EXEC, hold response in RESP.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_op;
          cnt_d    = cmd_cnt;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!is_legal(alu_op_q)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else if (is_shift(alu_op_q) && (cnt_q == '0)) begin
          // Zero-length shift returns the operand untouched.
          rsp_data_d = alu_a_q;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (is_shift(alu_op_q) && (cnt_q > CNT_W'(1))) begin
          // Feed the one-bit shifted value back as the next operand.
          alu_a_d = alu_result;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          rsp_data_d = alu_result;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ALU_CMD_DRIVER_CNT_EN
  logic [15:0] done_cnt_q;

  assign done_cnt = done_cnt_q;

  // Count completed response handshakes, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= '0;
    end else if (rsp_valid && rsp_ready) begin
      done_cnt_q <= done_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - self-checking bench for alu_cmd_driver paired with alu
module tb_alu_cmd_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic [3:0]  cmd_cnt = 4'd0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
`ifdef ALU_CMD_DRIVER_CNT_EN
  logic [15:0] done_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int done_exp = 0;

  always #5 clk = ~clk;

  alu #(.WIDTH(16)) u_alu (
    .a_i     (alu_a),
    .b_i     (alu_b),
    .op_i    (alu_op),
    .result_o(alu_result)
  );

  alu_cmd_driver #(.WIDTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_cnt   (cmd_cnt),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_result(alu_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
`ifdef ALU_CMD_DRIVER_CNT_EN
    .rsp_err   (rsp_err),
    .done_cnt  (done_cnt)
`else
    .rsp_err   (rsp_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the command should return, from the opcode table.
  function automatic logic [16:0] ref_rsp(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] cnt);
    int unsigned r;
    case (op)
      4'd0: r = (a + b) % 65536;
      4'd1: r = (a + 65536 - b) % 65536;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (a * (2 ** cnt)) % 65536;
      4'd6: r = a / (2 ** cnt);
      default: return {1'b1, 16'h0000};
    endcase
    return {1'b0, r[15:0]};
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [3:0] cnt);
    if ((op == 4'd5 || op == 4'd6) && cnt != 0) return 1 + cnt;
    return 2;
  endfunction

  // Issue one command and consume its response after 'stall' cycles of backpressure.
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] cnt, input int stall);
    logic [16:0] exp;
    int w;
    int lat;
    exp = ref_rsp(op, a, b, cnt);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_cnt = cnt;
    rsp_ready = (stall == 0);
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, " accept"}, {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a = ~a;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, ref_latency(op, cnt));
    check({tag, " data"}, {16'd0, rsp_data}, {16'd0, exp[15:0]});
    check({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp[16]});
    check({tag, " busy"}, {31'd0, cmd_ready}, 32'd0);
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      check({tag, " hold valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, " hold data"}, {16'd0, rsp_data}, {16'd0, exp[15:0]});
      check({tag, " hold busy"}, {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    done_exp = (done_exp + 1) % 65536;
    check({tag, " drop valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, " ready again"}, {31'd0, cmd_ready}, 32'd1);
`ifdef ALU_CMD_DRIVER_CNT_EN
    check({tag, " done_cnt"}, {16'd0, done_cnt}, done_exp);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, " rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check({tag, " rsp_data"}, {16'd0, rsp_data}, 32'd0);
    check({tag, " alu_a"}, {16'd0, alu_a}, 32'd0);
    check({tag, " alu_b"}, {16'd0, alu_b}, 32'd0);
    check({tag, " alu_op"}, {28'd0, alu_op}, 32'd0);
`ifdef ALU_CMD_DRIVER_CNT_EN
    check({tag, " done_cnt"}, {16'd0, done_cnt}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  cnt;

    #1 rst_n = 1'b0;
    #2 check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_cmd("add",      4'd0, 16'h1234, 16'h0F0F, 4'd0, 0);
    run_cmd("sub wrap", 4'd1, 16'h0000, 16'h0001, 4'd0, 0);
    run_cmd("shl 5",    4'd5, 16'h0001, 16'hAAAA, 4'd5, 0);
    run_cmd("shr 15",   4'd6, 16'h8000, 16'h0000, 4'd15, 0);
    run_cmd("shl 0",    4'd5, 16'hABCD, 16'h0000, 4'd0, 0);
    run_cmd("illegal",  4'd9, 16'hFFFF, 16'h1234, 4'd3, 0);
    run_cmd("after ill", 4'd3, 16'h0F00, 16'h00F0, 4'd0, 0);
    run_cmd("xor bp",   4'd4, 16'hFF00, 16'h0FF0, 4'd0, 4);
    run_cmd("shr 1",    4'd6, 16'h0003, 16'h0000, 4'd1, 0);
    run_cmd("ill 15",   4'd15, 16'h1111, 16'h2222, 4'd0, 2);

    // Reset in the middle of a long shift: nothing must come out.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 4'd5;
    cmd_a = 16'h0001;
    cmd_b = 16'h0000;
    cmd_cnt = 4'd10;
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("midshift op", {28'd0, alu_op}, 32'd5);
    repeat (2) begin
      @(negedge clk);
      check("midshift no rsp", {31'd0, rsp_valid}, 32'd0);
    end
    #2 rst_n = 1'b0;
    done_exp = 0;
    #1 check_reset_vals("async reset");
    repeat (3) begin
      @(negedge clk);
      check("in reset no rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset no rsp", {31'd0, rsp_valid}, 32'd0);
    run_cmd("add 1+1", 4'd0, 16'h0001, 16'h0001, 4'd0, 0);

    // Randomised commands, mostly legal, with random backpressure.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) < 8) op = 4'($urandom_range(0, 6));
      else op = 4'($urandom_range(7, 15));
      a = 16'($urandom);
      b = 16'($urandom);
      cnt = 4'($urandom);
      run_cmd($sformatf("rand%0d op%0d", i, op), op, a, b, cnt, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator side of the 16-bit ALU operand/opcode interface.
- Accepts commands over a valid/ready port, drives the ALU's A/B/OP inputs from registers, and captures the ALU's combinational RESULT.
- Returns the result over a valid/ready response port.
- Adds multi-bit shifts by iterating the ALU's single-bit shift ops, feeding each result back as A. Sits between the issue logic and the ALU instance in the parent datapath.

Parameters:
- WIDTH, 16, operand/result width; must equal the ALU data width.
- CNT_W, 4, width of shift-count field; max shift = 2^CNT_W - 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  4  opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SHL, 0110 SHR, others illegal.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B (ignored for shifts).
- cmd_cnt  input  CNT_W  shift amount (ignored for non-shifts).
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_op  output  4  to ALU OP.
- alu_result  input  WIDTH  from ALU RESULT (combinational, same cycle).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  WIDTH  result.
- rsp_err  output  1  command had an illegal opcode.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - State = IDLE.
  - alu_a, alu_b, rsp_data = 0.
  - alu_op = 0000.
  - rsp_valid, rsp_err = 0.
  - Internal shift counter = 0.
  - cmd_ready is forced 0 while rst_n = 0.
- States: IDLE, EXEC, RESP. cmd_ready = 1 only in IDLE (and rst_n = 1).
- IDLE:
  - On cmd_valid && cmd_ready: register cmd_a→alu_a, cmd_b→alu_b, cmd_op→alu_op, cmd_cnt→counter; go EXEC.
- EXEC (alu_result valid in this cycle):
  - Illegal op (0111–1111): rsp_data ← 0, rsp_err ← 1; go RESP.
  - Shift with counter = 0: rsp_data ← alu_a (unshifted), rsp_err ← 0; go RESP.
  - Shift with counter > 1: alu_a ← alu_result, counter ← counter − 1; stay in EXEC.
  - Shift with counter = 1, or any legal non-shift op: rsp_data ← alu_result, rsp_err ← 0; go RESP.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_err are held stable until rsp_valid && rsp_ready.
  - On handshake: rsp_valid → 0, go IDLE.
  - No new command is accepted in RESP; back-to-back throughput is one command per 3 cycles minimum.
- Latency (command accepted at edge k, rsp_valid high after edge):
  - Non-shift or illegal op: k+2.
  - Shift with cnt = n ≥ 1: k+1+n.
  - Shift with cnt = 0: k+2.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH with no carry output. Shifts fill with zero. All arithmetic is performed by the ALU; this block only routes values.
- alu_a/alu_b/alu_op hold their last values in IDLE and RESP (no toggling).
- Reset mid-operation: immediate return to reset values; any in-flight command is discarded and no response is produced.
- rsp_ready held high continuously: response is consumed on the first RESP cycle.

Optional Feature:
- Macro: ALU_CMD_DRIVER_CNT_EN.
- Defined:
  - Adds output port done_cnt [15:0], reset to 0.
  - Increments by 1 on every response handshake, including illegal-op responses.
  - Wraps from 0xFFFF to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD..OP_SHR.
  - OP_LAST_LEGAL = 4'b0110.
  - State encoding constants for IDLE/EXEC/RESP.
  - Function is_shift(op).
  - Function is_legal(op).
- No sub-module inside this block: the ALU is instantiated beside it in the parent wrapper, which connects alu_* ports.
- The bench instantiates alu and alu_cmd_driver together.

Test Plan:
- ADD: a=0x1234, b=0x0F0F, op=0000, rsp_ready=1 → rsp_valid after 2 cycles, rsp_data=0x2143, rsp_err=0.
- SUB wrap: a=0x0000, b=0x0001, op=0001 → rsp_data=0xFFFF.
- Multi-shift:
  - SHL a=0x0001, cnt=5 → rsp_data=0x0020, rsp_valid 6 cycles after accept.
  - SHR a=0x8000, cnt=15 → rsp_data=0x0001.
  - SHL cnt=0, a=0xABCD → rsp_data=0xABCD.
- Illegal op 1001, a=0xFFFF → rsp_data=0x0000, rsp_err=1. Next legal command clears rsp_err.
- Backpressure: XOR a=0xFF00, b=0x0FF0 with rsp_ready=0 for 4 cycles:
  - rsp_valid stays 1, rsp_data=0xF0F0 stable, cmd_ready=0 throughout.
  - After rsp_ready=1: cmd_ready=1 next cycle.
- Reset mid-shift: SHL cnt=10, assert rst_n=0 after 3 cycles:
  - All outputs return to reset values asynchronously; no response is produced.
  - After release, ADD 1+1 → rsp_data=0x0002.
  - With ALU_CMD_DRIVER_CNT_EN: done_cnt counts only completed handshakes and reads 0 after reset.
